// File: rtl/pc_pipe_reg.sv
// Fetch program counter with redirect/stall/flush control, the IF/ID PC pipeline
// register, and a circular history of the PCs that entered ID.
module pc_pipe_reg #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              INC        = 4,
    parameter int              HIST_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic                          Redirect,
    input  logic [XLEN-1:0]               Redirect_PC,
    output logic [XLEN-1:0]               PC_Out,
    output logic                          Misalign,
    output logic [XLEN-1:0]               PC_ID,
    output logic                          Valid_ID,
    input  logic [$clog2(HIST_DEPTH)-1:0] Hist_Sel,
    output logic [XLEN-1:0]               Hist_PC,
    output logic [$clog2(HIST_DEPTH):0]   Hist_Count
);

    localparam int HW = $clog2(HIST_DEPTH);
    localparam int CW = HW + 1;

    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] r_pc_id;
    logic            r_valid_id;
    logic [XLEN-1:0] r_hist [HIST_DEPTH];
    logic [HW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_load_id;
    logic [HW-1:0]   w_rd_idx;
    logic            w_sel_valid;

    // A fresh valid PC enters ID only when nothing redirects, flushes or stalls.
    assign w_load_id = !Redirect && !Flush && !Stall;

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers sample pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (Redirect) begin
            r_pc       <= {Redirect_PC[XLEN-1:2], 2'b00};
            r_misalign <= |Redirect_PC[1:0];
        end else if (!Stall) begin
            r_pc       <= r_pc + XLEN'(INC);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc_id    <= '0;
            r_valid_id <= 1'b0;
        end else if (Redirect || Flush) begin
            r_valid_id <= 1'b0;
        end else if (!Stall) begin
            r_pc_id    <= r_pc;
            r_valid_id <= 1'b1;
        end
    end

    // NOTE: the history array is reset because readback must return zeros for
    // entries never written; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_load_id) begin
            r_hist[r_wr_ptr] <= r_pc;
            r_wr_ptr         <= r_wr_ptr + HW'(1);
            if (r_count != CW'(HIST_DEPTH)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Entry written Hist_Sel writes ago sits just behind the write pointer.
    assign w_rd_idx    = r_wr_ptr - HW'(1) - Hist_Sel;
    assign w_sel_valid = CW'(Hist_Sel) < r_count;

    // NOTE: the combinational read assigns its output on every path, so no
    // latch can be inferred.
    always_comb begin
        Hist_PC = '0;
        if (w_sel_valid) begin
            Hist_PC = r_hist[w_rd_idx];
        end
    end

    assign PC_Out     = r_pc;
    assign Misalign   = r_misalign;
    assign PC_ID      = r_pc_id;
    assign Valid_ID   = r_valid_id;
    assign Hist_Count = r_count;

endmodule
